// File: rtl/out_seq_pkg.sv
// ============================================================================
// Module  : out_seq_pkg
// Brief   : State encodings and sizing helpers for the output-layer sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package out_seq_pkg;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_LOAD   = 3'd1;
    localparam logic [2:0] C_ST_COMMIT = 3'd2;
    localparam logic [2:0] C_ST_WAIT   = 3'd3;
    localparam logic [2:0] C_ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = C_ST_IDLE,
        LOAD   = C_ST_LOAD,
        COMMIT = C_ST_COMMIT,
        WAIT   = C_ST_WAIT,
        DONE   = C_ST_DONE
    } state_t;

    // Weights of every perceptron followed by one bias per perceptron.
    function automatic int num_words(input int num_input, input int num_pctn);
        return num_pctn * (num_input + 1);
    endfunction

    function automatic int cnt_width(input int num_input, input int num_pctn);
        return $clog2(num_words(num_input, num_pctn) + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/out_param_buf.sv
// ============================================================================
// Module  : out_param_buf
// Brief   : Word-indexed parameter register file feeding the weight/bias buses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_param_buf
    import out_seq_pkg::*;
#(
    parameter int NUM_INPUT = 3,
    parameter int NUM_PCTN  = 2,
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [CNT_W-1:0]                  idx,
    input  logic [WIDTH-1:0]                  wr_data,
    output logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0] weights,
    output logic [NUM_PCTN*WIDTH-1:0]         biases
);

    localparam int NUM_WORDS = num_words(NUM_INPUT, NUM_PCTN);
    localparam int NUM_W     = NUM_PCTN * NUM_INPUT;

    logic [WIDTH-1:0] words [NUM_WORDS];

    generate
        for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
            always_ff @(posedge clk) begin
                if (!rst) begin
                    words[k] <= '0;
                end else if (we && (idx == CNT_W'(k))) begin
                    words[k] <= wr_data;
                end
            end
        end

        // Word index p*NUM_INPUT+i lands in weight slot i of perceptron p.
        for (genvar k = 0; k < NUM_W; k++) begin : g_wmap
            assign weights[k*WIDTH +: WIDTH] = words[k];
        end

        for (genvar p = 0; p < NUM_PCTN; p++) begin : g_bmap
            assign biases[p*WIDTH +: WIDTH] = words[NUM_W + p];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/out_seq_ctrl.sv
// ============================================================================
// Module  : out_seq_ctrl
// Brief   : Loads a streamed parameter set, strobes the layer, captures its
//           activations. Define OUT_SEQ_CTRL_ABORT_EN to add the i_abort path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module out_seq_ctrl
    import out_seq_pkg::*;
#(
    parameter int NUM_INPUT = 3,
    parameter int NUM_PCTN  = 2,
    parameter int WIDTH     = 32,
    parameter int LAT       = 2
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef OUT_SEQ_CTRL_ABORT_EN
    input  logic                                i_abort,
`endif
    input  logic                                i_start,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [WIDTH-1:0]                    s_data,
    output logic [NUM_PCTN*NUM_INPUT*WIDTH-1:0] o_w,
    output logic [NUM_PCTN*WIDTH-1:0]           o_b,
    output logic                                o_wr,
    input  logic [NUM_PCTN*WIDTH-1:0]           i_a,
    output logic [NUM_PCTN*WIDTH-1:0]           o_a,
    output logic                                o_done,
    output logic                                o_busy
);

    localparam int NUM_WORDS = num_words(NUM_INPUT, NUM_PCTN);
    localparam int CNT_W     = cnt_width(NUM_INPUT, NUM_PCTN);
    localparam int LAT_W     = $clog2(LAT + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [LAT_W-1:0]   lat, lat_nxt;
    logic               wr_en;
    logic               capture;
    logic               abort;

`ifdef OUT_SEQ_CTRL_ABORT_EN
    assign abort = i_abort;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            lat   <= '0;
            o_a   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lat   <= lat_nxt;
            if (capture) begin
                o_a <= i_a;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_nxt   = lat;
        s_ready   = 1'b0;
        wr_en     = 1'b0;
        capture   = 1'b0;
        o_wr      = 1'b0;
        o_done    = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            LOAD: begin
                // Abort wins over an in-flight word, so nothing is accepted that cycle.
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        wr_en   = 1'b1;
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == CNT_W'(NUM_WORDS - 1)) begin
                            state_nxt = COMMIT;
                        end
                    end
                end
            end
            COMMIT: begin
                o_wr      = 1'b1;
                lat_nxt   = LAT_W'(LAT - 1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (lat == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    lat_nxt = lat - 1'b1;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy = (state != IDLE);

    out_param_buf #(
        .NUM_INPUT (NUM_INPUT),
        .NUM_PCTN  (NUM_PCTN),
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W)
    ) u_param_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_en),
        .idx     (cnt),
        .wr_data (s_data),
        .weights (o_w),
        .biases  (o_b)
    );

endmodule

`default_nettype wire
